// File: rtl/power_frame_packer.sv
// Packs N channel power values into SYNC/SEQ/data/CSUM byte frames for the UART FIFO.
// Latency: SYNC presented one cycle after the last channel goes fresh; stalls in place on fifo_full_i.
module power_frame_packer #(
  parameter int         NUM_CH    = 4,
  parameter int         DW        = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*DW-1:0]   data_i,
  input  logic [NUM_CH-1:0]      valid_i,
  input  logic                   fifo_full_i,
  output logic [7:0]             data_o,
  output logic                   wr_en_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int BPC = (DW + 7) / 8;
  localparam int PW  = BPC * 8;
  localparam int NB  = NUM_CH * BPC;
  localparam int CW  = $clog2(NB + 1);
  localparam int DCW = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SEQ, S_DATA, S_CSUM} state_t;

  state_t                 state;
  logic [NUM_CH*DW-1:0]   cap_q;
  logic [NUM_CH*DW-1:0]   snap_q;
  logic [NUM_CH-1:0]      fresh_q;
  logic [7:0]             seq_q;
  logic [7:0]             acc_q;
  logic [CW-1:0]          cnt_q;
  logic [7:0]             dbyte [NB];
  logic [7:0]             next_byte;
  logic                   start;
  logic                   last_data;
  logic [DCW-1:0]         n_drop;
  logic [16:0]            drop_sum;

  assign start     = (state == S_IDLE) && (&fresh_q);
  assign busy_o    = (state != S_IDLE);
  assign wr_en_o   = (state != S_IDLE) && !fifo_full_i;
  assign last_data = (cnt_q == CW'(NB - 1));

  // Frame-order byte view of the snapshot: each channel zero-extended, MSB byte first.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PW-1:0] ext;
    assign ext = PW'(snap_q[k*DW +: DW]);
    for (genvar b = 0; b < BPC; b++) begin : g_byte
      assign dbyte[k*BPC + b] = ext[(BPC-1-b)*8 +: 8];
    end
  end

  always_comb begin
    next_byte = dbyte[0];
    for (int i = 0; i < NB; i++)
      if (CW'(i) == cnt_q + CW'(1)) next_byte = dbyte[i];
  end

  // A strobe on the snapshot edge lands in a freshly cleared slot, so it never counts as a drop.
  always_comb begin
    n_drop = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (valid_i[k] && fresh_q[k] && !start) n_drop = n_drop + DCW'(1);
  end

  assign drop_sum = {1'b0, drop_cnt_o} + 17'(n_drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q      <= '0;
      snap_q     <= '0;
      fresh_q    <= '0;
      drop_cnt_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (valid_i[k]) cap_q[k*DW +: DW] <= data_i[k*DW +: DW];
      if (start) begin
        snap_q  <= cap_q;
        fresh_q <= valid_i;
      end else begin
        fresh_q <= fresh_q | valid_i;
      end
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      data_o       <= '0;
      frame_done_o <= 1'b0;
      seq_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state  <= S_SYNC;
          data_o <= SYNC_BYTE;
          acc_q  <= '0;
        end
        S_SYNC: if (wr_en_o) begin
          state  <= S_SEQ;
          data_o <= seq_q;
        end
        S_SEQ: if (wr_en_o) begin
          state  <= S_DATA;
          data_o <= dbyte[0];
          acc_q  <= acc_q + data_o;
          cnt_q  <= '0;
        end
        S_DATA: if (wr_en_o) begin
          acc_q <= acc_q + data_o;
          if (last_data) begin
            state  <= S_CSUM;
            data_o <= acc_q + data_o;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            data_o <= next_byte;
          end
        end
        S_CSUM: if (wr_en_o) begin
          state        <= S_IDLE;
          data_o       <= '0;
          seq_q        <= seq_q + 8'd1;
          frame_done_o <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/power_frame_packer.md
# power_frame_packer

Collects per-channel dB power results from the PowerConverter stage and serialises them into checksummed byte frames for the UartTx FIFO. It replaces the single-channel, low-byte-only path between dB conversion and UART with a parametrised N-channel, full-width packer that respects FIFO back-pressure. It sits between the per-channel PowerConverter instances and UartTx in the receiver signal chain.

## Interface
- NUM_CH, 4: number of power channels (1..16).
- DW, 16: width of each channel value (1..32); bytes per channel BPC = ceil(DW/8).
- SYNC_BYTE, 8'hA5: first byte of every frame.
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- data_i  in  NUM_CH*DW  channel values; channel k at bits [k*DW +: DW].
- valid_i  in  NUM_CH  per-channel strobe; channel k value captured when bit k is high.
- fifo_full_i  in  1  UartTx FIFO full.
- data_o  out  8  byte to UartTx.
- wr_en_o  out  1  UartTx write strobe; one byte per high cycle.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse after the checksum byte is written.
- drop_cnt_o  out  16  saturating count of overwritten, unsent channel values.

## Operation
- Capture bank: per channel, a DW-bit value register and a fresh bit. valid_i[k] loads the value and sets fresh[k].
- If valid_i[k] is high while fresh[k] is already set and not being cleared that cycle, the value is overwritten and drop_cnt_o increments, saturating at 16'hFFFF.
- A frame starts when the FSM is in IDLE and all fresh bits are set. On that edge:
  - all values are copied into a snapshot bank;
  - fresh[k] becomes valid_i[k];
  - a channel strobing on that same edge updates its capture register, not the snapshot, and no drop is counted.
- Frame byte order, length L = 3 + NUM_CH*BPC:
  - SYNC_BYTE;
  - SEQ, an 8-bit frame counter;
  - for channel 0 to NUM_CH-1, the snapshot value zero-extended to BPC*8 bits and sent MSB byte first;
  - CSUM, the sum mod 256 of SEQ and all data bytes (SYNC excluded).
- FSM states: IDLE -> SYNC -> SEQ -> DATA -> CSUM -> IDLE.
  - SYNC, SEQ and CSUM each advance on one write.
  - DATA uses a byte counter 0..NUM_CH*BPC-1 and leaves to CSUM after the last byte is written.
- SEQ increments by 1 when CSUM is written and wraps from 8'hFF to 8'h00.
- The checksum accumulator clears on entry to SYNC and adds each SEQ and data byte as it is written.
- If all fresh bits are set when CSUM is written, the next frame starts directly (CSUM -> IDLE -> SYNC, with the snapshot taken on the IDLE cycle).

## Timing
- Reset values: FSM IDLE; data_o 0, wr_en_o 0, busy_o 0, frame_done_o 0; drop_cnt_o 0; SEQ 0; all fresh bits 0; capture and snapshot registers 0.
- data_o is registered and holds the current-state byte.
- wr_en_o = (state in SYNC/SEQ/DATA/CSUM) && !fifo_full_i, combinational on fifo_full_i. The FSM advances only on a cycle with wr_en_o high.
- With fifo_full_i high, the state and data_o hold indefinitely and no byte is lost or repeated.
- Latency: the last fresh bit is set at edge t; the snapshot is taken at edge t+1; SYNC is on data_o with wr_en_o in cycle t+1 onward. With no back-pressure, the frame occupies L consecutive cycles.
- busy_o is high in all states except IDLE.
- frame_done_o is high for the cycle after the CSUM write.
- Reset asserted mid-frame aborts the frame immediately. The partial frame is not completed; the receiver resynchronises on SYNC_BYTE.

## Test plan
- Basic frame (NUM_CH=2, DW=16): strobe ch0=16'h1234, then ch1=16'h00FF, fifo_full_i low.
  - Required: wr_en_o high for 7 consecutive cycles carrying A5 00 12 34 00 FF 45.
  - Required: frame_done_o pulses once; drop_cnt_o stays 0.
- Back-pressure: same stimulus, with fifo_full_i high during bytes 2 and 5 for 3 cycles each.
  - Required: identical 7-byte sequence, with wr_en_o never high while full; 13 cycles total.
- Overrun: strobe ch0 three times (values 1, 2, 3), then ch1=5.
  - Required: the frame carries ch0=0003 and ch1=0005; drop_cnt_o=2.
- Strobe during frame: while the first frame is in DATA, strobe both channels with new values.
  - Required: the first frame is unaffected.
  - Required: the second frame starts immediately after frame_done_o with SEQ=01 and the new values.
- Wrap and odd width (NUM_CH=1, DW=12): send 257 frames with value 12'hABC.
  - Required: each frame is A5 SEQ 0A BC CSUM, where CSUM = (SEQ+0xC6) mod 256.
  - Required: SEQ runs 00..FF then 00.
- Reset mid-frame: assert rst during the DATA state.
  - Required: all outputs return to reset values asynchronously; no further writes until a fresh full set arrives; the next frame has SEQ=00.
